mdu: RTL and testbench

MDU -- requirements
Module: MDU

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_if.sv | 18 +
 rtl/mdu.sv | 101 ++++++++++
 tb/tb_mdu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and latencies for the multiply/divide unit; the instruction
// decoder imports the same op codes so both sides agree on the encoding.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline-side port bundle of the MDU: E-stage controls and operands in,
// busy and the architectural HI/LO registers out.
interface mdu_if;
    // Handshake: start/hi_we/lo_we are accepted only on an edge where busy is
    // low; busy is the sole back-pressure and the pipeline stalls on it.
    logic        start;
    logic [2:0]  op;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, hi_we, lo_we, A, B, input busy, HI, LO);
    modport slave  (input start, op, hi_we, lo_we, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: latches operands at start, counts down a
// fixed latency, then commits the combinational result into HI/LO.
module mdu
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mdu_if.slave       bus,
    output mdu_state_e dbg_state_o
);

    mdu_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;

    logic [63:0] prod_s, prod_u;
    logic [31:0] dvd, dvs, dvs_safe, quo, rem;
    logic [31:0] res_hi_d, res_lo_d;
    logic        commit_en;

    // One unsigned divider serves both div and divu; signed results are
    // re-signed afterwards (quotient toward zero, remainder follows dividend).
    always_comb begin
        prod_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u    = {32'd0, a_q} * {32'd0, b_q};
        dvd       = (op_q == MDU_DIVU) ? a_q : abs32(a_q);
        dvs       = (op_q == MDU_DIVU) ? b_q : abs32(b_q);
        dvs_safe  = (dvs == 32'd0) ? 32'd1 : dvs;
        quo       = dvd / dvs_safe;
        rem       = dvd % dvs_safe;
        res_hi_d  = hi_q;
        res_lo_d  = lo_q;
        commit_en = 1'b1;
        case (op_q)
            MDU_MULT:  {res_hi_d, res_lo_d} = prod_s;
            MDU_MULTU: {res_hi_d, res_lo_d} = prod_u;
            MDU_DIV: begin
                res_lo_d  = (a_q[31] ^ b_q[31]) ? (~quo + 32'd1) : quo;
                res_hi_d  = a_q[31] ? (~rem + 32'd1) : rem;
                commit_en = (b_q != 32'd0);
            end
            default: begin
                res_lo_d  = quo;
                res_hi_d  = rem;
                commit_en = (b_q != 32'd0);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (bus.start) begin
                        // Reserved ops are swallowed; start still drops any mthi/mtlo.
                        if (!bus.op[2]) begin
                            op_q    <= bus.op;
                            a_q     <= bus.A;
                            b_q     <= bus.B;
                            cnt_q   <= bus.op[1] ? DIV_CYCLES : MULT_CYCLES;
                            state_q <= MDU_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.A;
                        if (bus.lo_we) lo_q <= bus.A;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= MDU_IDLE;
                        busy_q  <= 1'b0;
                        if (commit_en) begin
                            hi_q <= res_hi_d;
                            lo_q <= res_lo_d;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboarded bench for the MDU: directed architectural vectors plus random
// operations checked against a plain-arithmetic reference model.
module tb_mdu;
    import mdu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    mdu_state_e dbg_state;

    mdu_if bus ();

    mdu dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [71:0] exp_q[$];          // {latency[7:0], hi[31:0], lo[31:0]}
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output bit wr,
                                      output logic [63:0] res);
        longint sa, sb, q, r;
        sa  = $signed(a);
        sb  = $signed(b);
        wr  = 1'b1;
        res = 64'd0;
        case (op)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {32'(r), 32'(q)};
                end
            end
            3'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else res = {a % b, a / b};
            end
            default: wr = 1'b0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic       prev_busy = 1'b0;
    int         busy_cnt  = 0;
    logic [71:0] ent;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (prev_busy && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'(busy_cnt), 64'd0);
                end else begin
                    ent = exp_q.pop_front();
                    check("latency", 64'(busy_cnt), 64'(ent[71:64]));
                    check("sb_hi", 64'(bus.HI), 64'(ent[63:32]));
                    check("sb_lo", 64'(bus.LO), 64'(ent[31:0]));
                end
                busy_cnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: plain; 1: start/mthi/mtlo attempted while busy; 2: mthi/mtlo alongside start
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode);
        bit          wr;
        logic [63:0] r;
        int          n;
        bit          saw_busy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.hi_we = (mode == 2);
        bus.lo_we = (mode == 2);
        if (!op[2]) begin
            ref_model(op, a, b, wr, r);
            if (wr) {model_hi, model_lo} = r;
            exp_q.push_back({(op[1] ? 8'd10 : 8'd5), model_hi, model_lo});
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        if (!op[2]) begin
            check("busy_rise", 64'(bus.busy), 64'd1);
            if (mode == 1) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.op    = MDU_MULTU;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.A     = 32'hDEAD;
                @(negedge clk);
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            n = 0;
            while (bus.busy && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (bus.busy) check("busy_timeout", 64'd1, 64'd0);
        end else begin
            saw_busy = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (bus.busy) saw_busy = 1'b1;
                @(negedge clk);
            end
            check("reserved_busy", 64'(saw_busy), 64'd0);
        end
        check("hi_model", 64'(bus.HI), 64'(model_hi));
        check("lo_model", 64'(bus.LO), 64'(model_lo));
    endtask

    task automatic do_mt(input bit we_hi, input bit we_lo, input logic [31:0] val);
        @(negedge clk);
        bus.hi_we = we_hi;
        bus.lo_we = we_lo;
        bus.A     = val;
        if (we_hi) model_hi = val;
        if (we_lo) model_lo = val;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mt_busy", 64'(bus.busy), 64'd0);
        check("mt_hi", 64'(bus.HI), 64'(model_hi));
        check("mt_lo", 64'(bus.LO), 64'(model_lo));
    endtask

    task automatic chk_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, "_hi"}, 64'(bus.HI), 64'(hi));
        check({tag, "_lo"}, 64'(bus.LO), 64'(lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(MDU_IDLE));
        chk_hl("rst", 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        do_mt(1'b1, 1'b0, 32'h11);
        do_mt(1'b0, 1'b1, 32'h22);
        chk_hl("preload", 32'h11, 32'h22);
        do_op(MDU_DIVU, 32'd9, 32'd0, 0);
        chk_hl("divu_zero", 32'h11, 32'h22);
        do_op(3'd4, 32'd5, 32'd6, 0);
        chk_hl("reserved", 32'h11, 32'h22);
        do_op(MDU_DIV, 32'hFFFF_FFF0, 32'd0, 0);
        chk_hl("div_zero", 32'h11, 32'h22);

        do_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        chk_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(MDU_DIVU, 32'd7, 32'd2, 0);
        chk_hl("divu", 32'd1, 32'd3);
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk_hl("div_ovf", 32'd0, 32'h8000_0000);

        do_mt(1'b1, 1'b1, 32'h55);
        chk_hl("mt_both", 32'h55, 32'h55);
        do_op(MDU_MULT, 32'h1234, 32'h10, 1);
        chk_hl("busy_writes", 32'd0, 32'h12340);
        do_op(MDU_MULTU, 32'd3, 32'd4, 2);
        chk_hl("start_wins", 32'd0, 32'd12);

        // abort a div three cycles in
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.A     = 32'hFFFF_FFF9;
        bus.B     = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        chk_hl("abort", 32'd0, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        do_op(MDU_MULT, 32'd4, 32'd5, 0);
        chk_hl("post_abort", 32'd0, 32'd20);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop[2] && $urandom_range(0, 1) == 1) rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0)
                do_mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            do_op(rop, ra, rb, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
